serializer_tx: RTL and testbench

//   Parallel-to-serial transmitter for the accelerator's serial link. Takes WIDTH-bit words on a

---
 rtl/serializer_tx.sv | 168 ++++++++++++++++
 tb/tb_serializer_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serializer_tx.sv
// serializer_tx: parallel-to-serial transmitter for the accelerator's serial link.
//
// Takes WIDTH-bit words on a valid/ready handshake and drives them LSB-first on serial_data_o.
// frame_sync_o is high during bit 0 of each frame. GAP idle cycles separate consecutive frames.
// A one-entry holding register decouples the word source from the shifter, so a new word can be
// accepted while the current frame is still shifting out.
//
// Parameters
//   WIDTH  bits per frame (>= 2)
//   GAP    idle serial_clk cycles between consecutive frames (>= 0)
//
// Ports
//   serial_clk     in   bit clock, all logic on posedge
//   rst_n          in   asynchronous active-low reset
//   tx_data_i      in   word to transmit
//   tx_valid_i     in   tx_data_i valid
//   tx_ready_o     out  holding register empty; word taken on an edge with valid && ready
//   serial_data_o  out  serial bit, LSB first (registered)
//   frame_sync_o   out  high exactly during bit 0 of each frame (registered)
//   busy_o         out  frame in progress, i.e. shifting or in the inter-frame gap (registered)
//   tx_done_o      out  one-cycle pulse coincident with bit WIDTH-1 on serial_data_o (registered)
module serializer_tx #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GAP   = 1
) (
  input  logic             serial_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             serial_data_o,
  output logic             frame_sync_o,
  output logic             busy_o,
  output logic             tx_done_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  // The gap counter holds GAP-1 down to 0; keep it at least one bit wide even when unused.
  localparam int unsigned GapW = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [GapW-1:0] GapLoad = (GAP > 0) ? GapW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             serial_q, serial_d;
  logic             sync_q, sync_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             try_load;
  logic [CntW-1:0]  cnt_inc;

  // No combinational path from tx_valid_i to tx_ready_o.
  assign tx_ready_o = ~hold_full_q;
  assign accept     = tx_valid_i & ~hold_full_q;
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    serial_d    = 1'b0;
    sync_d      = 1'b0;
    done_d      = 1'b0;
    try_load    = 1'b0;

    case (state_q)
      StIdle: begin
        try_load = 1'b1;
      end
      StShift: begin
        if (cnt_q == LastBit) begin
          if (GAP > 0) begin
            state_d = StGap;
            gap_d   = GapLoad;
          end else begin
            // Back-to-back frames: next word (if any) goes out with no idle bit.
            try_load = 1'b1;
          end
        end else begin
          cnt_d    = cnt_inc;
          shift_d  = shift_q >> 1;
          serial_d = shift_q[1];
          done_d   = (cnt_inc == LastBit);
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          try_load = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Load from the holding register, or drop back to idle when nothing is waiting.
    if (try_load) begin
      if (hold_full_q) begin
        state_d     = StShift;
        shift_d     = hold_q;
        serial_d    = hold_q[0];
        sync_d      = 1'b1;
        cnt_d       = '0;
        hold_full_d = 1'b0;
      end else begin
        state_d = StIdle;
      end
    end

    // Accept and load never coincide: accept requires the holding register to be empty.
    if (accept) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge serial_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      serial_q    <= 1'b0;
      sync_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      serial_q    <= serial_d;
      sync_q      <= sync_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign serial_data_o = serial_q;
  assign frame_sync_o  = sync_q;
  assign tx_done_o     = done_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_serializer_tx.sv
// Bench for serializer_tx: two instances (GAP=1 and GAP=0) share one randomized stimulus stream.
// A frame-level reference model schedules each accepted word's start cycle and predicts every
// output bit from that schedule.
module tb_serializer_tx;

  localparam int W = 32;

  logic          serial_clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic [1:0]    rdy, sd, fs, done, bsy;

  always #5 serial_clk = ~serial_clk;

  serializer_tx #(.WIDTH(W), .GAP(1)) u_dut_gap1 (
    .serial_clk    (serial_clk),
    .rst_n         (rst_n),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (rdy[0]),
    .serial_data_o (sd[0]),
    .frame_sync_o  (fs[0]),
    .busy_o        (bsy[0]),
    .tx_done_o     (done[0])
  );

  serializer_tx #(.WIDTH(W), .GAP(0)) u_dut_gap0 (
    .serial_clk    (serial_clk),
    .rst_n         (rst_n),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (rdy[1]),
    .serial_data_o (sd[1]),
    .frame_sync_o  (fs[1]),
    .busy_o        (bsy[1]),
    .tx_done_o     (done[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state, one set per instance.
  int           gap_of[2] = '{1, 0};
  logic [W-1:0] cur_word[2];
  int           cur_start[2];
  bit           have_cur[2];
  logic [W-1:0] pend_word[2];
  int           pend_start[2];
  bit           pend_v[2];
  bit           acc[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      have_cur[i] = 1'b0;
      pend_v[i]   = 1'b0;
      acc[i]      = 1'b0;
    end
  endtask

  // One rising edge: a waiting word starts when its scheduled cycle arrives; a new word is
  // taken only if nothing was waiting before this edge. A frame starts one cycle after it is
  // accepted, but no earlier than WIDTH+GAP cycles after the previous frame started.
  task automatic model_edge();
    bit rp;
    int ns;
    for (int i = 0; i < 2; i++) begin
      acc[i] = 1'b0;
      rp = !pend_v[i];
      if (pend_v[i] && pend_start[i] == cyc) begin
        cur_word[i]  = pend_word[i];
        cur_start[i] = cyc;
        have_cur[i]  = 1'b1;
        pend_v[i]    = 1'b0;
      end
      if (tx_valid && rp) begin
        ns = cyc + 1;
        if (have_cur[i] && cur_start[i] + W + gap_of[i] > ns) ns = cur_start[i] + W + gap_of[i];
        pend_v[i]     = 1'b1;
        pend_word[i]  = tx_data;
        pend_start[i] = ns;
        acc[i]        = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int off;
    bit in_frame;
    for (int i = 0; i < 2; i++) begin
      off      = cyc - cur_start[i];
      in_frame = have_cur[i] && off >= 0 && off < W;
      check_eq($sformatf("ready%0d", i), rdy[i], !pend_v[i]);
      check_eq($sformatf("serial%0d", i), sd[i], in_frame ? cur_word[i][off] : 1'b0);
      check_eq($sformatf("sync%0d", i), fs[i], in_frame && off == 0);
      check_eq($sformatf("done%0d", i), done[i], in_frame && off == W - 1);
      check_eq($sformatf("busy%0d", i), bsy[i], have_cur[i] && off >= 0 && off < W + gap_of[i]);
    end
  endtask

  task automatic step();
    @(posedge serial_clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge serial_clk);
    compare_all();
  endtask

  logic [W-1:0] words[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'hDEAD_BEEF};

  initial begin
    int idx;
    bit found;

    // Reset held with clock running, then released.
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Single known word.
    tx_data  = 32'hA5A5_0F01;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = $urandom;
    step();
    check_eq("t2_sync", fs[0], 1);
    check_eq("t2_bit0", sd[0], 1);
    step();
    check_eq("t2_sync_low", fs[0], 0);
    check_eq("t2_bit1", sd[0], 0);
    repeat (7) step();
    check_eq("t2_bit8", sd[0], 1);
    repeat (30) step();
    check_eq("t2_idle_busy", bsy[0], 0);

    // Streamed words with valid held; advance on GAP=1 instance acceptance.
    idx      = 0;
    tx_valid = 1'b1;
    tx_data  = words[0];
    for (int n = 0; n < 300 && idx < 4; n++) begin
      step();
      if (acc[0]) idx++;
      tx_data = (idx < 4) ? words[idx] : $urandom;
    end
    check_eq("t3_all_accepted", idx, 4);
    tx_valid = 1'b0;
    repeat (80) step();

    // Random traffic: bursts of valid with data changing every cycle (also under backpressure).
    for (int n = 0; n < 2000; n++) begin
      tx_valid = ($urandom_range(0, 9) < 7);
      tx_data  = $urandom;
      step();
    end
    tx_valid = 1'b0;
    repeat (80) step();

    // Reset at bit 13 of a GAP=1 frame with a word waiting.
    tx_valid = 1'b1;
    found    = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      tx_data = $urandom;
      step();
      if (have_cur[0] && cyc - cur_start[0] == 13 && pend_v[0]) found = 1'b1;
    end
    check_eq("t6_reached_bit13", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_serial", sd, 2'b00);
    check_eq("t6_async_sync", fs, 2'b00);
    check_eq("t6_async_done", done, 2'b00);
    check_eq("t6_async_busy", bsy, 2'b00);
    check_eq("t6_async_ready", rdy, 2'b11);
    model_reset();
    tx_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (50) step();

    // Traffic resumes normally after the aborted frame.
    for (int n = 0; n < 300; n++) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = $urandom;
      step();
    end
    tx_valid = 1'b0;
    repeat (80) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
